// File: rtl/cond_unit_pkg.sv
// Shared constants for the conditional-execution unit: condition codes,
// ALU flag bit positions and FlagWrite enable positions.
package cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions within the 5-bit ALUFlags bus {N,Z,C,V,Q}
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Q = 0;

  // Bit positions within the 4-bit stored Flags {N,Z,C,V}
  localparam int SF_N = FLAG_N - 1;
  localparam int SF_Z = FLAG_Z - 1;
  localparam int SF_C = FLAG_C - 1;
  localparam int SF_V = FLAG_V - 1;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Execute-stage inputs and memory-stage outputs of cond_unit as one bundle.
// Single-cycle register stage: no valid/ready; StallM holds, FlushM bubbles.
interface cond_unit_if;
  logic [3:0]  CondE;
  logic [4:0]  ALUFlags;
  logic [1:0]  FlagWriteE;
  logic        QWriteE;
  logic        QClear;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        PCSrcE;
  logic [31:0] ALUResultE;
  logic [3:0]  WA3E;
  logic        StallM;
  logic        FlushM;
  logic        CondExE;
  logic [3:0]  Flags;
  logic        QFlag;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        PCSrcM;
  logic [31:0] ALUResultM;
  logic [3:0]  WA3M;

  modport master (
    output CondE, ALUFlags, FlagWriteE, QWriteE, QClear, RegWriteE, MemWriteE,
           PCSrcE, ALUResultE, WA3E, StallM, FlushM,
    input  CondExE, Flags, QFlag, RegWriteM, MemWriteM, PCSrcM, ALUResultM, WA3M
  );

  modport slave (
    input  CondE, ALUFlags, FlagWriteE, QWriteE, QClear, RegWriteE, MemWriteE,
           PCSrcE, ALUResultE, WA3E, StallM, FlushM,
    output CondExE, Flags, QFlag, RegWriteM, MemWriteM, PCSrcM, ALUResultM, WA3M
  );
endinterface

// File: rtl/cond_unit_cond_check.sv
// Condition-code evaluator: decides from the stored {N,Z,C,V} whether the
// executing instruction's condition field passes.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] Flags,
  output logic       CondExE
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = Flags[SF_N];
  assign w_z = Flags[SF_Z];
  assign w_c = Flags[SF_C];
  assign w_v = Flags[SF_V];

  always_comb begin
    CondExE = 1'b0;
    case (CondE)
      COND_EQ: CondExE = w_z;
      COND_NE: CondExE = ~w_z;
      COND_CS: CondExE = w_c;
      COND_CC: CondExE = ~w_c;
      COND_MI: CondExE = w_n;
      COND_PL: CondExE = ~w_n;
      COND_VS: CondExE = w_v;
      COND_VC: CondExE = ~w_v;
      COND_HI: CondExE = w_c & ~w_z;
      COND_LS: CondExE = ~w_c | w_z;
      COND_GE: CondExE = (w_n == w_v);
      COND_LT: CondExE = (w_n != w_v);
      COND_GT: CondExE = ~w_z & (w_n == w_v);
      COND_LE: CondExE = w_z | (w_n != w_v);
      COND_AL: CondExE = 1'b1;
      COND_NV: CondExE = 1'b0;
      default: CondExE = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: condition check, NZCV/sticky-Q flag storage
// and the E/M pipeline register carrying condition-gated controls.
module cond_unit
  import cond_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  CondE,
  input  logic [4:0]  ALUFlags,
  input  logic [1:0]  FlagWriteE,
  input  logic        QWriteE,
  input  logic        QClear,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        PCSrcE,
  input  logic [31:0] ALUResultE,
  input  logic [3:0]  WA3E,
  input  logic        StallM,
  input  logic        FlushM,
  output logic        CondExE,
  output logic [3:0]  Flags,
  output logic        QFlag,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        PCSrcM,
  output logic [31:0] ALUResultM,
  output logic [3:0]  WA3M
);

  logic [3:0]  r_flags;
  logic        r_q;
  logic        r_reg_write;
  logic        r_mem_write;
  logic        r_pc_src;
  logic [31:0] r_alu_result;
  logic [3:0]  r_wa3;

  logic        w_cond_ex;
  logic        w_update;
  logic        w_q_set;

  cond_check u_cond_check (
    .CondE   (CondE),
    .Flags   (r_flags),
    .CondExE (w_cond_ex)
  );

  // Flags follow the executing instruction, so FlushM does not gate them
  assign w_update = ~StallM & w_cond_ex;
  assign w_q_set  = w_update & QWriteE & ALUFlags[FLAG_Q];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
      r_q     <= 1'b0;
    end else begin
      if (w_update && FlagWriteE[FW_NZ]) begin
        r_flags[SF_N] <= ALUFlags[FLAG_N];
        r_flags[SF_Z] <= ALUFlags[FLAG_Z];
      end
      if (w_update && FlagWriteE[FW_CV]) begin
        r_flags[SF_C] <= ALUFlags[FLAG_C];
        r_flags[SF_V] <= ALUFlags[FLAG_V];
      end
      // A saturation on the same edge as a software clear must stay visible
      if (w_q_set) begin
        r_q <= 1'b1;
      end else if (QClear) begin
        r_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_pc_src     <= 1'b0;
      r_alu_result <= 32'h0;
      r_wa3        <= 4'h0;
    end else if (!StallM) begin
      if (FlushM) begin
        r_reg_write  <= 1'b0;
        r_mem_write  <= 1'b0;
        r_pc_src     <= 1'b0;
        r_alu_result <= 32'h0;
        r_wa3        <= 4'h0;
      end else begin
        r_reg_write  <= RegWriteE & w_cond_ex;
        r_mem_write  <= MemWriteE & w_cond_ex;
        r_pc_src     <= PCSrcE & w_cond_ex;
        r_alu_result <= ALUResultE;
        r_wa3        <= WA3E;
      end
    end
  end

  assign CondExE    = w_cond_ex;
  assign Flags      = r_flags;
  assign QFlag      = r_q;
  assign RegWriteM  = r_reg_write;
  assign MemWriteM  = r_mem_write;
  assign PCSrcM     = r_pc_src;
  assign ALUResultM = r_alu_result;
  assign WA3M       = r_wa3;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_cond_unit;
  import cond_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_unit_if bus ();

  cond_unit dut (
    .clk        (clk),
    .reset      (reset),
    .CondE      (bus.CondE),
    .ALUFlags   (bus.ALUFlags),
    .FlagWriteE (bus.FlagWriteE),
    .QWriteE    (bus.QWriteE),
    .QClear     (bus.QClear),
    .RegWriteE  (bus.RegWriteE),
    .MemWriteE  (bus.MemWriteE),
    .PCSrcE     (bus.PCSrcE),
    .ALUResultE (bus.ALUResultE),
    .WA3E       (bus.WA3E),
    .StallM     (bus.StallM),
    .FlushM     (bus.FlushM),
    .CondExE    (bus.CondExE),
    .Flags      (bus.Flags),
    .QFlag      (bus.QFlag),
    .RegWriteM  (bus.RegWriteM),
    .MemWriteM  (bus.MemWriteM),
    .PCSrcM     (bus.PCSrcM),
    .ALUResultM (bus.ALUResultM),
    .WA3M       (bus.WA3M)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit          m_valid = 1'b0;
  logic        m_n, m_z, m_c, m_v, m_q;
  logic        m_regw, m_memw, m_pcs;
  logic [31:0] m_res;
  logic [3:0]  m_wa3;

  // Conditions come in pairs: odd code is the inverse of the even one
  function automatic logic ref_cond(logic [3:0] c, logic n, logic z, logic cf, logic v);
    logic base;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) begin
    logic pass;
    if (reset) begin
      m_valid = 1'b1;
      {m_n, m_z, m_c, m_v, m_q} = 5'b0;
      {m_regw, m_memw, m_pcs} = 3'b0;
      m_res = 32'h0;
      m_wa3 = 4'h0;
    end else if (m_valid) begin
      pass = ref_cond(bus.CondE, m_n, m_z, m_c, m_v);
      if (!bus.StallM && pass) begin
        if (bus.FlagWriteE[1]) begin m_n = bus.ALUFlags[4]; m_z = bus.ALUFlags[3]; end
        if (bus.FlagWriteE[0]) begin m_c = bus.ALUFlags[2]; m_v = bus.ALUFlags[1]; end
      end
      if (!bus.StallM && pass && bus.QWriteE && bus.ALUFlags[0]) m_q = 1'b1;
      else if (bus.QClear) m_q = 1'b0;
      if (!bus.StallM) begin
        if (bus.FlushM) begin
          {m_regw, m_memw, m_pcs} = 3'b0;
          m_res = 32'h0;
          m_wa3 = 4'h0;
        end else begin
          m_regw = bus.RegWriteE && pass;
          m_memw = bus.MemWriteE && pass;
          m_pcs  = bus.PCSrcE && pass;
          m_res  = bus.ALUResultE;
          m_wa3  = bus.WA3E;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_valid) begin
        chk("m_condex", 32'(bus.CondExE), 32'(ref_cond(bus.CondE, m_n, m_z, m_c, m_v)));
        chk("m_flags", 32'(bus.Flags), 32'({m_n, m_z, m_c, m_v}));
        chk("m_qflag", 32'(bus.QFlag), 32'(m_q));
        chk("m_ctrl", 32'({bus.RegWriteM, bus.MemWriteM, bus.PCSrcM}), 32'({m_regw, m_memw, m_pcs}));
        chk("m_result", bus.ALUResultM, m_res);
        chk("m_wa3", 32'(bus.WA3M), 32'(m_wa3));
      end
    end
  end

  task automatic drive_idle();
    bus.CondE      = COND_AL;
    bus.ALUFlags   = 5'b0;
    bus.FlagWriteE = 2'b00;
    bus.QWriteE    = 1'b0;
    bus.QClear     = 1'b0;
    bus.RegWriteE  = 1'b0;
    bus.MemWriteE  = 1'b0;
    bus.PCSrcE     = 1'b0;
    bus.ALUResultE = 32'h0;
    bus.WA3E       = 4'h0;
    bus.StallM     = 1'b0;
    bus.FlushM     = 1'b0;
  endtask

  task automatic next();
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    logic [3:0] fv;
    logic [3:0] cv;
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);

    // Reset state, then AL with Z result
    reset = 1'b0;
    bus.FlagWriteE = 2'b11;
    bus.ALUFlags   = 5'b01000;
    #3;
    chk("rst_flags", 32'(bus.Flags), 32'h0);
    chk("rst_q", 32'(bus.QFlag), 32'h0);
    chk("rst_regw", 32'(bus.RegWriteM), 32'h0);
    chk("rst_result", bus.ALUResultM, 32'h0);
    chk("rst_wa3", 32'(bus.WA3M), 32'h0);
    chk("al_condex", 32'(bus.CondExE), 32'h1);

    // NE fails with Z=1: nothing written
    next();
    bus.CondE = COND_NE; bus.RegWriteE = 1'b1;
    bus.FlagWriteE = 2'b11; bus.ALUFlags = 5'b10000;
    #3;
    chk("al_flags", 32'(bus.Flags), 32'h4);
    chk("ne_condex", 32'(bus.CondExE), 32'h0);
    next();
    #3;
    chk("ne_regw", 32'(bus.RegWriteM), 32'h0);
    chk("ne_flags", 32'(bus.Flags), 32'h4);

    // Sticky Q
    next();
    bus.QWriteE = 1'b1; bus.ALUFlags = 5'b00011;
    for (int i = 0; i < 5; i++) begin
      next();
      bus.ALUFlags = 5'($urandom_range(0, 31));
      bus.FlagWriteE = 2'($urandom_range(0, 3));
      #3;
      chk("q_sticky", 32'(bus.QFlag), 32'h1);
    end
    next();
    bus.QClear = 1'b1;
    next();
    #3;
    chk("q_clear", 32'(bus.QFlag), 32'h0);
    bus.QClear = 1'b1; bus.QWriteE = 1'b1; bus.ALUFlags = 5'b00001;
    next();
    #3;
    chk("q_set_wins", 32'(bus.QFlag), 32'h1);

    // Stall over flush, then flush
    bus.RegWriteE = 1'b1; bus.ALUResultE = 32'h12345678; bus.WA3E = 4'h5;
    next();
    bus.StallM = 1'b1; bus.FlushM = 1'b1; bus.ALUResultE = 32'hDEADBEEF;
    bus.RegWriteE = 1'b1; bus.WA3E = 4'h9;
    #3;
    chk("load_result", bus.ALUResultM, 32'h12345678);
    next();
    bus.FlushM = 1'b1; bus.RegWriteE = 1'b1; bus.ALUResultE = 32'hDEADBEEF;
    #3;
    chk("stall_result", bus.ALUResultM, 32'h12345678);
    chk("stall_regw", 32'(bus.RegWriteM), 32'h1);
    next();
    #3;
    chk("flush_regw", 32'(bus.RegWriteM), 32'h0);
    chk("flush_result", bus.ALUResultM, 32'h0);

    // Pin the condition model: N=1, Z=0, C=1, V=0
    bus.FlagWriteE = 2'b11; bus.ALUFlags = 5'b10100;
    next();
    bus.CondE = COND_GE; #3; chk("pin_ge", 32'(bus.CondExE), 32'h0);
    bus.CondE = COND_LT; #1; chk("pin_lt", 32'(bus.CondExE), 32'h1);
    next();
    bus.CondE = COND_HI; #3; chk("pin_hi", 32'(bus.CondExE), 32'h1);
    bus.CondE = COND_LS; #1; chk("pin_ls", 32'(bus.CondExE), 32'h0);
    next();
    bus.CondE = COND_NV; #3; chk("pin_nv", 32'(bus.CondExE), 32'h0);

    // Full 16x16 sweep
    for (int f = 0; f < 16; f++) begin
      fv = 4'(f);
      next();
      bus.FlagWriteE = 2'b11;
      bus.ALUFlags = {fv, 1'b0};
      for (int c = 0; c < 16; c++) begin
        cv = 4'(c);
        next();
        bus.CondE = cv;
        #3;
        chk("sweep", 32'(bus.CondExE), 32'(ref_cond(cv, fv[3], fv[2], fv[1], fv[0])));
      end
    end

    // Reset mid-stream kills the in-flight write
    next();
    bus.RegWriteE = 1'b1;
    next();
    bus.RegWriteE = 1'b1; bus.FlagWriteE = 2'b11; bus.ALUFlags = 5'b11110;
    bus.QWriteE = 1'b1; bus.ALUFlags[0] = 1'b1;
    reset = 1'b1;
    #3;
    chk("pre_rst_regw", 32'(bus.RegWriteM), 32'h1);
    next();
    reset = 1'b0;
    #3;
    chk("mid_rst_regw", 32'(bus.RegWriteM), 32'h0);
    chk("mid_rst_flags", 32'(bus.Flags), 32'h0);

    // Randomized traffic checked by the every-cycle compare
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.CondE      = 4'($urandom_range(0, 15));
      bus.ALUFlags   = 5'($urandom_range(0, 31));
      bus.FlagWriteE = 2'($urandom_range(0, 3));
      bus.QWriteE    = ($urandom_range(0, 3) == 0);
      bus.QClear     = ($urandom_range(0, 7) == 0);
      bus.RegWriteE  = 1'($urandom_range(0, 1));
      bus.MemWriteE  = 1'($urandom_range(0, 1));
      bus.PCSrcE     = 1'($urandom_range(0, 1));
      bus.ALUResultE = $urandom;
      bus.WA3E       = 4'($urandom_range(0, 15));
      bus.StallM     = ($urandom_range(0, 3) == 0);
      bus.FlushM     = ($urandom_range(0, 3) == 0);
      reset          = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk (rising edge) and reset.
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- CondE  in  4  instruction condition field
- ALUFlags  in  5  {N,Z,C,V,Q} from the execute ALU
- FlagWriteE  in  2  bit1 enables N,Z update; bit0 enables C,V update
- QWriteE  in  1  saturating op (QADD/QSUB) may set Q
- QClear  in  1  software clear of sticky Q
- RegWriteE, MemWriteE, PCSrcE  in  1 each  decoded controls
- ALUResultE  in  32  ALU result
- WA3E  in  4  destination register
- StallM  in  1  hold the E/M register
- FlushM  in  1  insert bubble into the E/M register
- CondExE  out  1  condition passed, combinational
- Flags  out  4  stored {N,Z,C,V}
- QFlag  out  1  stored sticky Q
- RegWriteM, MemWriteM, PCSrcM  out  1 each  gated registered controls
- ALUResultM  out  32  registered result
- WA3M  out  4  registered destination

Function
REQ-003 CondExE SHALL be evaluated from the stored Flags (pre-update) and CondE: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
REQ-004 An update edge SHALL be a rising clk with reset=0, StallM=0 and CondExE=1.
REQ-005 On an update edge, N,Z SHALL load ALUFlags[4:3] if FlagWriteE[1], and C,V SHALL load ALUFlags[2:1] if FlagWriteE[0]; otherwise the flags SHALL hold.
REQ-006 On an update edge with QWriteE=1 and ALUFlags[0]=1, QFlag SHALL be set to 1; QFlag SHALL otherwise be sticky.
REQ-007 QClear=1 on a rising edge with reset=0 SHALL clear QFlag regardless of StallM; if a Q set occurs on the same edge, the set SHALL win.
REQ-008 FlushM SHALL NOT suppress flag or Q updates, since flags belong to the executing instruction.
REQ-009 On an edge with StallM=0 and FlushM=0, the E/M register SHALL load RegWriteE&CondExE, MemWriteE&CondExE, PCSrcE&CondExE, ALUResultE and WA3E.
REQ-010 On an edge with StallM=0 and FlushM=1, RegWriteM, MemWriteM and PCSrcM SHALL load 0, and ALUResultM and WA3M SHALL load 0.
REQ-011 On an edge with StallM=1, all E/M outputs SHALL hold, and StallM SHALL take priority over FlushM.
REQ-012 Latency SHALL be: CondExE 0 cycles; Flags, QFlag and the M outputs 1 cycle.
REQ-013 No arithmetic SHALL be performed, and all data paths SHALL be width-preserving.

Reset
REQ-014 On a reset edge, Flags SHALL be 4'b0000, QFlag 0, RegWriteM, MemWriteM and PCSrcM 0, ALUResultM 32'h0 and WA3M 4'h0.
REQ-015 Reset SHALL take priority over StallM, FlushM and QClear.
REQ-016 Reset asserted between two operations SHALL leave no in-flight write enabled.

Structure
REQ-017 A shared package SHALL hold the condition-code constants (EQ..AL, NV), flag bit indices (N=4, Z=3, C=2, V=1, Q=0) and the FlagWrite bit positions.
REQ-018 The condition table SHALL be one combinational sub-module, cond_check (inputs CondE and Flags, output CondExE).
REQ-019 Flag storage and the E/M register SHALL stay in cond_unit.

Verification
REQ-020 Reset, then CondE=1110, FlagWriteE=11, ALUFlags=5'b01000 -> CondExE=1; after 1 edge Flags=4'b0100.
REQ-021 With Flags=0100 (Z=1): CondE=0001, RegWriteE=1, FlagWriteE=11, ALUFlags=5'b10000 -> CondExE=0, RegWriteM=0, Flags stay 0100.
REQ-022 QWriteE=1, ALUFlags=5'b00011, CondE=1110 -> QFlag=1 and stays 1 over 5 further non-saturating ops. QClear alone -> QFlag=0. QClear with a Q set on the same edge -> QFlag=1.
REQ-023 StallM=1 and FlushM=1 with ALUResultE=32'hDEADBEEF -> ALUResultM unchanged. Then StallM=0, FlushM=1 -> RegWriteM=0 and ALUResultM=0.
REQ-024 Sweep all 16 CondE codes against all 16 Flags values -> CondExE matches the REQ-003 table, with 1111 always 0.
REQ-025 Reset asserted mid-stream with RegWriteE=1 -> RegWriteM=0 and Flags=0 on the next cycle.
